// File: rtl/proc_pkg.sv
// proc_pkg: shared definitions for the processor front end.
//   ifu_state_e        - instruction fetch unit FSM states
//   END_INSTR_DEFAULT  - default instruction word that halts fetching
package proc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    READY,
    HALT
  } ifu_state_e;

  localparam logic [15:0] END_INSTR_DEFAULT = 16'hFFFF;

endpackage : proc_pkg

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches instruction words from a synchronous instruction
// RAM (one cycle read latency) into IR for the mapping block.
//
// Ports:
//   clk         - clock, rising edge
//   rst_n       - synchronous active-low reset
//   start       - one-cycle pulse, begins a program at start_addr (IDLE/HALT only)
//   start_addr  - first instruction address
//   fetch_req   - advance to the next instruction (honoured in READY only)
//   jump_en     - with fetch_req, redirect pc to jump_addr before fetching
//   jump_addr   - jump target
//   iram_en     - instruction RAM read enable (high in FETCH only)
//   iram_addr   - instruction RAM read address (always equals pc)
//   iram_rdata  - instruction RAM read data, valid the cycle after iram_en
//   IR          - instruction register
//   ir_valid    - IR holds a decodable instruction (READY)
//   pc          - address of the next instruction to fetch
//   halted      - END_INSTR has been loaded (HALT)
//   fetch_count - saturating count of IR loads; present only when the macro
//                 IFU_FETCH_COUNT_EN is defined
module instr_fetch_unit
  import proc_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 8,
  parameter int unsigned        DATA_W    = 16,
  parameter logic [DATA_W-1:0]  END_INSTR = END_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              fetch_req,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              iram_en,
  output logic [ADDR_W-1:0] iram_addr,
  input  logic [DATA_W-1:0] iram_rdata,
  output logic [DATA_W-1:0] IR,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
`ifdef IFU_FETCH_COUNT_EN
  ,
  output logic [15:0]       fetch_count
`endif
);

  localparam logic [ADDR_W-1:0] PC_ONE = 1;

  ifu_state_e        state, state_nxt;
  logic [ADDR_W-1:0] pc_q, pc_nxt;
  logic [DATA_W-1:0] ir_q;
  logic              ir_load;

  // Next-state and next-pc logic
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    ir_load   = 1'b0;
    unique case (state)
      IDLE, HALT: begin
        if (start) begin
          pc_nxt    = start_addr;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        // RAM data is valid now: capture it and step pc (wraps naturally)
        ir_load   = 1'b1;
        pc_nxt    = pc_q + PC_ONE;
        state_nxt = (iram_rdata == END_INSTR) ? HALT : READY;
      end
      READY: begin
        if (fetch_req) begin
          if (jump_en) begin
            pc_nxt = jump_addr;
          end
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, pc and IR registers; reset wins over an in-flight WAIT load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pc_q  <= '0;
      ir_q  <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      if (ir_load) begin
        ir_q <= iram_rdata;
      end
    end
  end

  assign iram_en   = (state == FETCH);
  assign iram_addr = pc_q;
  assign IR        = ir_q;
  assign pc        = pc_q;
  assign ir_valid  = (state == READY);
  assign halted    = (state == HALT);

`ifdef IFU_FETCH_COUNT_EN
  logic        start_ok;
  logic [15:0] fcnt_q;

  // Only a start that is actually accepted (IDLE/HALT) clears the count
  assign start_ok = start && ((state == IDLE) || (state == HALT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcnt_q <= '0;
    end else if (start_ok) begin
      fcnt_q <= '0;
    end else if (ir_load && (fcnt_q != '1)) begin
      fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign fetch_count = fcnt_q;
`endif

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: self-checking bench for instr_fetch_unit with a
// one-cycle-latency instruction RAM model and an IR/pc scoreboard.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  start_addr = '0;
  logic        fetch_req = 1'b0;
  logic        jump_en = 1'b0;
  logic [7:0]  jump_addr = '0;
  logic        iram_en;
  logic [7:0]  iram_addr;
  logic [15:0] iram_rdata = '0;
  logic [15:0] IR;
  logic        ir_valid;
  logic [7:0]  pc;
  logic        halted;
`ifdef IFU_FETCH_COUNT_EN
  logic [15:0] fetch_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:255];

  typedef struct {
    logic [15:0] ir;
    logic [7:0]  pc;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] word;
    logic [7:0]  exp_pc;
    logic        exp_halt;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(8), .DATA_W(16), .END_INSTR(16'hFFFF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .fetch_req  (fetch_req),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .iram_en    (iram_en),
    .iram_addr  (iram_addr),
    .iram_rdata (iram_rdata),
    .IR         (IR),
    .ir_valid   (ir_valid),
    .pc         (pc),
    .halted     (halted)
`ifdef IFU_FETCH_COUNT_EN
    ,
    .fetch_count(fetch_count)
`endif
  );

  // Synchronous RAM: data appears the cycle after iram_en
  always @(posedge clk) begin
    if (iram_en) iram_rdata <= mem[iram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each new READY/HALT entry must match the oldest expectation
  logic prev_evt = 1'b0;
  always @(negedge clk) begin
    logic evt;
    exp_t e;
    evt = ir_valid | halted;
    if (evt && !prev_evt) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: IR %0h pc %0h with empty scoreboard", IR, pc);
      end else begin
        e = sbq.pop_front();
        check("sb_ir", 32'(IR), 32'(e.ir));
        check("sb_pc", 32'(pc), 32'(e.pc));
      end
    end
    prev_evt = evt;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    fetch_req = 1'b0;
    jump_en = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic do_start(input logic [7:0] a);
    start_addr = a;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_fetch(input logic j, input logic [7:0] a);
    fetch_req = 1'b1;
    jump_en = j;
    jump_addr = a;
    step();
    fetch_req = 1'b0;
    jump_en = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(ir_valid || halted) && n < 20) begin
      step();
      n++;
    end
    check(name, 32'(ir_valid | halted), 32'd1);
  endtask

  initial begin
    vecs[0] = '{8'h20, 16'h1234, 8'h21, 1'b0};
    vecs[1] = '{8'hFF, 16'h00AA, 8'h00, 1'b0};
    vecs[2] = '{8'h40, 16'hFFFF, 8'h41, 1'b1};
    vecs[3] = '{8'h7F, 16'hFFFE, 8'h80, 1'b0};
    vecs[4] = '{8'h00, 16'h0000, 8'h01, 1'b0};
    for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);

    // Reset state
    step();
    do_reset();
    check("rst_ir", 32'(IR), 0);
    check("rst_pc", 32'(pc), 0);
    check("rst_ir_valid", 32'(ir_valid), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_iram_en", 32'(iram_en), 0);
    check("rst_iram_addr", 32'(iram_addr), 0);

    // Program 5, 7, FFFF with exact cycle timing
    mem[0] = 16'h0005; mem[1] = 16'h0007; mem[2] = 16'hFFFF;
    sbq.push_back('{16'h0005, 8'h01});
    do_start(8'h00);
    check("fetch_iram_en", 32'(iram_en), 1);
    check("fetch_iram_addr", 32'(iram_addr), 0);
    check("fetch_ir_valid", 32'(ir_valid), 0);
    step();
    check("wait_iram_en", 32'(iram_en), 0);
    check("wait_ir_valid", 32'(ir_valid), 0);
    step();
    check("ready_ir_valid", 32'(ir_valid), 1);
    check("ready_ir", 32'(IR), 16'h0005);
    sbq.push_back('{16'h0007, 8'h02});
    do_fetch(1'b0, 8'h00);
    check("refetch_ir_valid", 32'(ir_valid), 0);
    check("refetch_iram_addr", 32'(iram_addr), 1);
    step();
    step();
    check("second_ir", 32'(IR), 16'h0007);
    check("second_pc", 32'(pc), 2);
    sbq.push_back('{16'hFFFF, 8'h03});
    do_fetch(1'b0, 8'h00);
    step();
    step();
    check("halt_halted", 32'(halted), 1);
    check("halt_ir_valid", 32'(ir_valid), 0);
    check("halt_ir", 32'(IR), 16'hFFFF);
    do_fetch(1'b1, 8'h20);
    check("halt_fetch_ignored", 32'(halted), 1);
    check("halt_pc_held", 32'(pc), 3);
    check("halt_iram_en", 32'(iram_en), 0);
    sbq.push_back('{16'h0007, 8'h02});
    do_start(8'h01);
    check("halt_start_clears", 32'(halted), 0);
    check("halt_start_fetch", 32'(iram_en), 1);
    check("halt_start_addr", 32'(iram_addr), 1);
    wait_done("halt_restart_timeout");

    // Jump from READY with pc=3; lone jump_en and start in READY ignored
    do_reset();
    mem[2] = 16'h0011; mem[16] = 16'h0099;
    sbq.push_back('{16'h0011, 8'h03});
    do_start(8'h02);
    wait_done("jump_setup_timeout");
    jump_en = 1'b1; jump_addr = 8'h30;
    step();
    jump_en = 1'b0;
    check("lone_jump_pc", 32'(pc), 3);
    check("lone_jump_valid", 32'(ir_valid), 1);
    do_start(8'h60);
    check("ready_start_pc", 32'(pc), 3);
    check("ready_start_valid", 32'(ir_valid), 1);
    check("ready_start_iram_en", 32'(iram_en), 0);
    sbq.push_back('{16'h0099, 8'h11});
    do_fetch(1'b1, 8'h10);
    check("jump_iram_en", 32'(iram_en), 1);
    check("jump_iram_addr", 32'(iram_addr), 8'h10);
    wait_done("jump_timeout");

    // Reset during WAIT discards the in-flight word
    do_reset();
    mem[0] = 16'h0005;
    do_start(8'h00);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("wrst_ir", 32'(IR), 0);
    check("wrst_pc", 32'(pc), 0);
    check("wrst_valid", 32'(ir_valid), 0);
    check("wrst_iram_en", 32'(iram_en), 0);
    step();
    check("wrst_no_load_ir", 32'(IR), 0);
    check("wrst_no_load_valid", 32'(ir_valid), 0);

    // Table-driven single fetches
    for (int i = 0; i < 5; i++) begin
      do_reset();
      mem[vecs[i].addr] = vecs[i].word;
      sbq.push_back('{vecs[i].word, vecs[i].exp_pc});
      do_start(vecs[i].addr);
      wait_done("vec_timeout");
      check("vec_halted", 32'(halted), 32'(vecs[i].exp_halt));
      check("vec_ir_valid", 32'(ir_valid), 32'(!vecs[i].exp_halt));
    end

`ifdef IFU_FETCH_COUNT_EN
    do_reset();
    check("cnt_reset", 32'(fetch_count), 0);
    mem[0] = 16'h0005; mem[1] = 16'h0007; mem[2] = 16'hFFFF;
    sbq.push_back('{16'h0005, 8'h01});
    sbq.push_back('{16'h0007, 8'h02});
    sbq.push_back('{16'hFFFF, 8'h03});
    do_start(8'h00);
    wait_done("cnt_t1");
    do_fetch(1'b0, 8'h00);
    wait_done("cnt_t2");
    do_fetch(1'b0, 8'h00);
    wait_done("cnt_t3");
    check("cnt_three", 32'(fetch_count), 3);
    sbq.push_back('{16'h0007, 8'h02});
    do_start(8'h01);
    check("cnt_start_clear", 32'(fetch_count), 0);
    wait_done("cnt_t4");
    check("cnt_one", 32'(fetch_count), 1);
`endif

    step();
    check("sb_drained", 32'(sbq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_instr_fetch_unit
